// File: rtl/param_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : param_sync_fifo
// Description : Single-clock FIFO with registered read data and registered
//               status flags. The flags reflect the post-edge occupancy, so
//               they never lag the count by a cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : WIDTH    data word width (>=1)
//               DEPTH    number of entries (power of two, >=4)
//               AF_LEVEL fifo_almost_full asserts when count >= AF_LEVEL
//               AE_LEVEL fifo_almost_empty asserts when count <= AE_LEVEL
// Ports       : clk               clock, rising edge
//               rst_              synchronous active-low reset
//               fifo_data_in      write data
//               fifo_write        write request (ignored while full)
//               fifo_read         read request (ignored while empty)
//               fifo_data_out     registered read data, held between reads
//               fifo_data_valid   one-cycle strobe after an accepted read
//               fifo_full/empty/almost_full/almost_empty  status flags
//               fifo_count        occupancy 0..DEPTH
// Optional    : define PARAM_SYNC_FIFO_ERR_FLAGS_EN to add
//               fifo_err_clr (in), fifo_overflow / fifo_underflow (out),
//               sticky flags for writes-while-full and reads-while-empty.
// ============================================================================
module param_sync_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [WIDTH-1:0]         fifo_data_in,
  input  logic                     fifo_write,
  input  logic                     fifo_read,
  output logic [WIDTH-1:0]         fifo_data_out,
  output logic                     fifo_data_valid,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_almost_full,
  output logic                     fifo_almost_empty,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  ,
  input  logic                     fifo_err_clr,
  output logic                     fifo_overflow,
  output logic                     fifo_underflow
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_AF_CNT    = c_CW'(AF_LEVEL);
  localparam logic [c_CW-1:0] c_AE_CNT    = c_CW'(AE_LEVEL);
  localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_CW-1:0]  r_wr_ptr;
  logic [c_CW-1:0]  r_rd_ptr;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_full;
  logic             r_empty;
  logic             r_almost_full;
  logic             r_almost_empty;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [c_CW-1:0]  w_count;
  logic [c_CW-1:0]  w_count_nxt;

  // The extra pointer bit distinguishes full from empty, so the occupancy is
  // simply the modulo-2*DEPTH difference of the two pointers.
  always_comb begin
    w_wr_acc    = fifo_write && !r_full;
    w_rd_acc    = fifo_read  && !r_empty;
    w_count     = r_wr_ptr - r_rd_ptr;
    w_count_nxt = w_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = w_count + c_ONE;
      2'b01:   w_count_nxt = w_count - c_ONE;
      default: w_count_nxt = w_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_data_out     <= '0;
      r_data_valid   <= 1'b0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ONE;
      end
      if (w_rd_acc) begin
        r_data_out <= r_mem[r_rd_ptr[c_AW-1:0]];
        r_rd_ptr   <= r_rd_ptr + c_ONE;
      end
      r_data_valid   <= w_rd_acc;
      // Flags are computed from the next occupancy so they land together
      // with the pointer update instead of one cycle later.
      r_full         <= (w_count_nxt == c_DEPTH_CNT);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= c_AF_CNT);
      r_almost_empty <= (w_count_nxt <= c_AE_CNT);
    end
  end

  // Storage is deliberately left out of reset; an entry is only ever read
  // after it has been written.
  always_ff @(posedge clk) begin
    if (rst_ && w_wr_acc) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= fifo_data_in;
    end
  end

  assign fifo_data_out     = r_data_out;
  assign fifo_data_valid   = r_data_valid;
  assign fifo_full         = r_full;
  assign fifo_empty        = r_empty;
  assign fifo_almost_full  = r_almost_full;
  assign fifo_almost_empty = r_almost_empty;
  assign fifo_count        = w_count;

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_set;
  logic w_unf_set;

  always_comb begin
    w_ovf_set = fifo_write && r_full;
    w_unf_set = fifo_read  && r_empty;
  end

  // Sticky error flags; a new error in the clear cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (fifo_err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_set) begin
        r_underflow <= 1'b1;
      end else if (fifo_err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign fifo_overflow  = r_overflow;
  assign fifo_underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
- REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits (>=1).
- REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, >=4.
- REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, count at or above which fifo_almost_full asserts (1..DEPTH-1).
- REQ-004 SHALL have parameter AE_LEVEL, default 2, count at or below which fifo_almost_empty asserts (1..DEPTH-1).
- REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
- REQ-006 SHALL have port rst_  input  1  reset; one clock; reset is synchronous and active-low.
- REQ-007 SHALL have port fifo_data_in  input  WIDTH  write data.
- REQ-008 SHALL have port fifo_write  input  1  write request.
- REQ-009 SHALL have port fifo_read  input  1  read request.
- REQ-010 SHALL have port fifo_data_out  output  WIDTH  registered read data.
- REQ-011 SHALL have port fifo_data_valid  output  1  high for one cycle when fifo_data_out holds newly read data.
- REQ-012 SHALL have ports fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty  output  1 each  status flags.
- REQ-013 SHALL have port fifo_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
- REQ-014 Write SHALL be accepted iff fifo_write=1 and fifo_full=0; accepted data stored at write pointer, pointer advanced mod DEPTH.
- REQ-015 Read SHALL be accepted iff fifo_read=1 and fifo_empty=0; entry at read pointer loaded into fifo_data_out at that edge, pointer advanced mod DEPTH.
- REQ-016 Read latency SHALL be one cycle: fifo_data_valid=1 in the cycle after an accepted read, else 0; fifo_data_out holds its last value otherwise.
- REQ-017 fifo_count SHALL update at the same edge: +1 write only, -1 read only, unchanged for both or neither.
- REQ-018 All flags SHALL be registered and reflect post-edge occupancy with no extra cycle lag: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
- REQ-019 Simultaneous read and write with 0<count<DEPTH SHALL both be accepted; count and flags unchanged.
- REQ-020 When full, simultaneous read+write SHALL accept the read only; write dropped.
- REQ-021 When empty, simultaneous read+write SHALL accept the write only; no fifo_data_valid.
- REQ-022 Pointers SHALL be $clog2(DEPTH)+1 bits; wrap past DEPTH-1 SHALL preserve FIFO order indefinitely.
- REQ-023 Storage array SHALL NOT be reset; contents unobservable until written.

Reset
- REQ-024 With rst_=0 at a rising clk edge: pointers=0, fifo_count=0, fifo_data_out=0, fifo_data_valid=0, fifo_empty=1, fifo_almost_empty=1, fifo_full=0, fifo_almost_full=0.
- REQ-025 Reset mid-operation SHALL discard all stored entries; requests in the reset cycle SHALL be ignored.
- REQ-026 First write SHALL be accepted at the first edge with rst_=1.

Configuration
- REQ-027 Macro PARAM_SYNC_FIFO_ERR_FLAGS_EN SHALL, when defined, add ports fifo_overflow (output 1), fifo_underflow (output 1), fifo_err_clr (input 1).
- REQ-028 With macro: fifo_overflow sets on write while full, fifo_underflow sets on read while empty; both sticky until fifo_err_clr=1 or reset; set beats clear in the same cycle.
- REQ-029 Without macro: those ports SHALL be absent and dropped requests silently ignored.

Verification (DEPTH=16, WIDTH=16, AF_LEVEL=14, AE_LEVEL=2)
- REQ-030 Reset then write 0x0001..0x0010 -> fifo_full=1 after 16th edge, almost_full=1 after 14th edge, fifo_count=16.
- REQ-031 From full, read 16 times -> data_out 0x0001..0x0010 in order, each with data_valid one cycle after read; fifo_empty=1 after 16th read.
- REQ-032 Write 10, read 10, repeat 5 times (pointer wrap) -> all 50 words read back in order, count returns to 0.
- REQ-033 count=8, read+write 20 cycles -> count stays 8, no flag change; full: read+write -> count 15, write data lost; empty: read+write -> count 1, data_valid=0.
- REQ-034 Fill 5 words, assert rst_=0 one cycle -> count=0, empty=1, data_out=0; next read -> no data_valid.
- REQ-035 With PARAM_SYNC_FIFO_ERR_FLAGS_EN: write when full -> fifo_overflow=1 held until fifo_err_clr pulse; read when empty -> fifo_underflow=1.
